aes256_iter_encrypt_ctrl: RTL and testbench

Iterative AES-256 encryption engine controller. It sequences one shared round datapath through the 14 AES-256 rounds and expands round keys on the fly, instead of unrolling 14 rounds and the full 1920-bit key schedule. It accepts a 128-bit block and a 256-bit key over a valid/ready handshake and returns ciphertext over a second valid/ready handshake. It is the area-reduced alternative to the fully combinational NK8 encrypt path, built from the same round primitives.

---
 rtl/aes_pkg.sv | 136 +++++++++++++
 rtl/aes_round_unit.sv | 20 ++
 rtl/aes256_iter_encrypt_ctrl.sv | 137 +++++++++++++
 tb/tb_aes256_iter_encrypt_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions for the iterative AES-256 encrypt controller.
// Contents: FSM state encoding, width constants, the Rcon table, and the
// byte-level round primitives (S-box, SubBytes, ShiftRows, MixColumns) plus
// the AES-256 eight-word key-expansion step.
// Block layout: byte 0 is at [127:120], column-major (byte n = row n%4, col n/4).
package aes_pkg;

    localparam int BYTE_W  = 8;
    localparam int WORD_W  = 32;
    localparam int BLOCK_W = 128;
    localparam int KEY_W   = 256;
    localparam int NR_256  = 14;

    typedef logic [BYTE_W-1:0] byte_t;
    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } aes_state_e;

    // Round constant for key-expansion step idx (1..7 used by AES-256).
    function automatic byte_t rcon(input logic [3:0] idx);
        byte_t r;
        case (idx)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic byte_t xtime(input byte_t a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic byte_t gf_mul(input byte_t a, input byte_t b);
        byte_t p;
        byte_t t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < BYTE_W; i++) begin
            p = p ^ (b[i] ? t : 8'h00);
            t = xtime(t);
        end
        return p;
    endfunction

    // S-box computed as affine(x^254); x^254 is the product of x^(2^k), k=1..7,
    // which also maps 0 to 0 as the AES inverse requires.
    function automatic byte_t sbox(input byte_t a);
        byte_t sq;
        byte_t inv;
        sq  = a;
        inv = 8'h01;
        for (int k = 1; k < BYTE_W; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic word_t sub_word(input word_t w);
        word_t r;
        for (int i = 0; i < 4; i++) begin
            r[BYTE_W*i +: BYTE_W] = sbox(w[BYTE_W*i +: BYTE_W]);
        end
        return r;
    endfunction

    function automatic logic [BLOCK_W-1:0] sub_bytes(input logic [BLOCK_W-1:0] s);
        logic [BLOCK_W-1:0] r;
        for (int i = 0; i < 16; i++) begin
            r[BYTE_W*i +: BYTE_W] = sbox(s[BYTE_W*i +: BYTE_W]);
        end
        return r;
    endfunction

    // Row r is rotated left by r columns: out(r,c) = in(r,(c+r)%4).
    function automatic logic [BLOCK_W-1:0] shift_rows(input logic [BLOCK_W-1:0] s);
        logic [BLOCK_W-1:0] r;
        for (int row = 0; row < 4; row++) begin
            for (int col = 0; col < 4; col++) begin
                r[(BLOCK_W-1) - BYTE_W*(row + 4*col) -: BYTE_W] =
                    s[(BLOCK_W-1) - BYTE_W*(row + 4*((col + row) % 4)) -: BYTE_W];
            end
        end
        return r;
    endfunction

    function automatic logic [BLOCK_W-1:0] mix_columns(input logic [BLOCK_W-1:0] s);
        logic [BLOCK_W-1:0] r;
        byte_t a0, a1, a2, a3;
        for (int col = 0; col < 4; col++) begin
            a0 = s[(BLOCK_W-1) - WORD_W*col              -: BYTE_W];
            a1 = s[(BLOCK_W-1) - WORD_W*col - BYTE_W     -: BYTE_W];
            a2 = s[(BLOCK_W-1) - WORD_W*col - 2*BYTE_W   -: BYTE_W];
            a3 = s[(BLOCK_W-1) - WORD_W*col - 3*BYTE_W   -: BYTE_W];
            r[(BLOCK_W-1) - WORD_W*col -: WORD_W] = {
                xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return r;
    endfunction

    // One AES-256 schedule step: eight new words from the previous eight.
    function automatic logic [KEY_W-1:0] key_expand(input logic [KEY_W-1:0] k,
                                                    input logic [3:0]       idx);
        word_t w [8];
        word_t n [8];
        word_t t;
        for (int i = 0; i < 8; i++) begin
            w[i] = k[(KEY_W-1) - WORD_W*i -: WORD_W];
        end
        t    = sub_word({w[7][23:0], w[7][31:24]}) ^ {rcon(idx), 24'h000000};
        n[0] = w[0] ^ t;
        n[1] = w[1] ^ n[0];
        n[2] = w[2] ^ n[1];
        n[3] = w[3] ^ n[2];
        n[4] = w[4] ^ sub_word(n[3]);
        n[5] = w[5] ^ n[4];
        n[6] = w[6] ^ n[5];
        n[7] = w[7] ^ n[6];
        return {n[0], n[1], n[2], n[3], n[4], n[5], n[6], n[7]};
    endfunction

endpackage

// File: rtl/aes_round_unit.sv
// One combinational AES encryption round.
// Ports: state_i (round input block), rk_i (round key), last_i (1 = final
// round, MixColumns skipped), state_o (round output block).
module aes_round_unit
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] state_i,
    input  logic [BLOCK_W-1:0] rk_i,
    input  logic               last_i,
    output logic [BLOCK_W-1:0] state_o
);

    logic [BLOCK_W-1:0] sr_s;
    logic [BLOCK_W-1:0] mc_s;

    assign sr_s    = shift_rows(sub_bytes(state_i));
    assign mc_s    = last_i ? sr_s : mix_columns(sr_s);
    assign state_o = mc_s ^ rk_i;

endmodule

// File: rtl/aes256_iter_encrypt_ctrl.sv
// Iterative AES-256 encryption controller: one shared round datapath run for
// 14 cycles, with round keys expanded on the fly two rounds at a time.
// Ports: clk, reset (async, active high); request side in_valid/in_ready with
// plaintext[127:0] and key[255:0]; response side out_valid/out_ready with
// ciphertext[127:0]; status busy (ROUND or DONE) and round_idx[3:0].
module aes256_iter_encrypt_ctrl
    import aes_pkg::*;
#(
    parameter int NR      = 14,
    parameter bit ZEROIZE = 1'b1
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] plaintext,
    input  logic [KEY_W-1:0]   key,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] ciphertext,
    output logic               busy,
    output logic [3:0]         round_idx
);

    if (NR != NR_256) begin : g_nr_check
        $error("aes256_iter_encrypt_ctrl: only NR=14 is supported");
    end

    aes_state_e         fsm_q;
    logic [BLOCK_W-1:0] state_reg_q;
    logic [KEY_W-1:0]   key_q;
    logic [3:0]         rnd_q;
    logic [3:0]         rnd_d;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;
    logic [BLOCK_W-1:0] ciphertext_q;

    logic [KEY_W-1:0]   next_key_s;
    logic [BLOCK_W-1:0] rk_s;
    logic               last_s;
    logic [BLOCK_W-1:0] round_out_s;

    // key_q always holds the two most recent round keys: odd rounds use its
    // low half; even rounds advance the schedule and use the new high half.
    assign next_key_s = key_expand(key_q, {1'b0, rnd_q[3:1]});
    assign rk_s       = rnd_q[0] ? key_q[BLOCK_W-1:0] : next_key_s[KEY_W-1:BLOCK_W];
    assign last_s     = (rnd_q == 4'd14);
    assign rnd_d      = rnd_q + 4'd1;

    aes_round_unit u_round (
        .state_i (state_reg_q),
        .rk_i    (rk_s),
        .last_i  (last_s),
        .state_o (round_out_s)
    );

    // Control FSM with registered outputs and the round/key datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q        <= ST_IDLE;
            state_reg_q  <= 128'h0;
            key_q        <= 256'h0;
            rnd_q        <= 4'd0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            ciphertext_q <= 128'h0;
        end else begin
            case (fsm_q)
                ST_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        state_reg_q <= plaintext ^ key[KEY_W-1:BLOCK_W];
                        key_q       <= key;
                        rnd_q       <= 4'd1;
                        in_ready_q  <= 1'b0;
                        busy_q      <= 1'b1;
                        fsm_q       <= ST_ROUND;
                    end else begin
                        in_ready_q  <= 1'b1;
                        fsm_q       <= ST_IDLE;
                    end
                end
                ST_ROUND: begin
                    state_reg_q <= round_out_s;
                    key_q       <= rnd_q[0] ? key_q : next_key_s;
                    if (last_s) begin
                        // round_idx stays at 14 while the result is offered
                        out_valid_q  <= 1'b1;
                        ciphertext_q <= round_out_s;
                        fsm_q        <= ST_DONE;
                    end else begin
                        rnd_q        <= rnd_d;
                        fsm_q        <= ST_ROUND;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        rnd_q       <= 4'd0;
                        fsm_q       <= ST_IDLE;
                        if (ZEROIZE) begin
                            state_reg_q <= 128'h0;
                            key_q       <= 256'h0;
                        end else begin
                            state_reg_q <= state_reg_q;
                            key_q       <= key_q;
                        end
                    end else begin
                        fsm_q       <= ST_DONE;
                    end
                end
                default: begin
                    // unreachable encoding: fall back to the reset state
                    fsm_q        <= ST_IDLE;
                    state_reg_q  <= 128'h0;
                    key_q        <= 256'h0;
                    rnd_q        <= 4'd0;
                    in_ready_q   <= 1'b1;
                    out_valid_q  <= 1'b0;
                    busy_q       <= 1'b0;
                    ciphertext_q <= 128'h0;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign round_idx  = rnd_q;
    assign ciphertext = ciphertext_q;

endmodule

// File: tb/tb_aes256_iter_encrypt_ctrl.sv
// Directed bench for aes256_iter_encrypt_ctrl using FIPS-197 C.3 and
// SP800-38A F.1.5 vectors; inputs driven and outputs sampled on negedges.
module tb_aes256_iter_encrypt_ctrl;

    localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C3_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] F_KEY  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] F_PT   = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] F_CT   = 128'hf3eed1bdb5d2a03c064b5a7e3db181f8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] plaintext = 128'h0;
    logic [255:0] key = 256'h0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] ciphertext;
    logic         busy;
    logic [3:0]   round_idx;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int acc = 0;
    int t1 = 0;
    logic [127:0] held_ct;

    aes256_iter_encrypt_ctrl #(.NR(14), .ZEROIZE(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .plaintext  (plaintext),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ciphertext (ciphertext),
        .busy       (busy),
        .round_idx  (round_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send(input logic [127:0] pt, input logic [255:0] k);
        int n = 0;
        while (in_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("send_in_ready", {255'h0, in_ready}, 256'h1);
        plaintext = pt;
        key       = k;
        in_valid  = 1'b1;
        acc       = cyc;
        @(negedge clk);
        in_valid  = 1'b0;
        plaintext = ~pt;
        key       = ~k;
    endtask

    task automatic wait_ov(input string tag);
        int n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {255'h0, out_valid}, 256'h1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        @(negedge clk);
        @(negedge clk);
        chk("reset_ctrl", {in_ready, out_valid, busy, round_idx}, {1'b1, 1'b0, 1'b0, 4'd0});
        chk("reset_ct", ciphertext, 128'h0);
        chk("reset_state_reg", dut.state_reg_q, 128'h0);
        chk("reset_key_reg", dut.key_q, 256'h0);
        reset = 1'b0;
        @(negedge clk);

        // FIPS-197 C.3 with latency check; out_ready high
        out_ready = 1'b1;
        send(C3_PT, C3_KEY);
        chk("c3_busy", {in_ready, busy, round_idx}, {1'b0, 1'b1, 4'd1});
        wait_ov("c3_out_valid");
        chk("c3_latency", cyc - acc, 15);
        chk("c3_ct", ciphertext, C3_CT);
        @(negedge clk);
        chk("c3_after_hs", {in_ready, out_valid, busy, round_idx}, {1'b1, 1'b0, 1'b0, 4'd0});
        chk("c3_zeroize", {dut.state_reg_q, dut.key_q}, 384'h0);

        // SP800-38A F.1.5 with round_idx stepping 1..14
        send(F_PT, F_KEY);
        for (int i = 1; i <= 14; i++) begin
            chk("f15_round_idx", round_idx, i);
            @(negedge clk);
        end
        wait_ov("f15_out_valid");
        chk("f15_done", {busy, round_idx}, {1'b1, 4'd14});
        chk("f15_ct", ciphertext, F_CT);
        @(negedge clk);

        // Backpressure for 20 cycles, then handshake with a coincident request
        out_ready = 1'b0;
        send(C3_PT, C3_KEY);
        wait_ov("bp_out_valid");
        held_ct = ciphertext;
        for (int i = 0; i < 20; i++) begin
            chk("bp_hold", {in_ready, out_valid, ciphertext}, {1'b0, 1'b1, C3_CT});
            @(negedge clk);
        end
        chk("bp_stable", ciphertext, held_ct);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        plaintext = F_PT;
        key       = F_KEY;
        @(negedge clk);
        chk("bp_only_out_hs", {in_ready, out_valid, busy}, {1'b1, 1'b0, 1'b0});
        acc = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_next_accept", {busy, round_idx}, {1'b1, 4'd1});
        wait_ov("bp2_out_valid");
        chk("bp2_latency", cyc - acc, 15);
        chk("bp2_ct", ciphertext, F_CT);
        @(negedge clk);

        // in_valid with a different key during ROUND is ignored
        send(C3_PT, C3_KEY);
        repeat (3) @(negedge clk);
        in_valid  = 1'b1;
        plaintext = F_PT;
        key       = F_KEY;
        chk("ign_in_ready", {255'h0, in_ready}, 256'h0);
        @(negedge clk);
        in_valid = 1'b0;
        wait_ov("ign_out_valid");
        chk("ign_ct", ciphertext, C3_CT);
        @(negedge clk);

        // Reset at round 7, then a clean C.3 request
        send(F_PT, F_KEY);
        for (int n = 0; n < 20 && round_idx !== 4'd7; n++) @(negedge clk);
        chk("rst7_reached", round_idx, 4'd7);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        @(negedge clk);
        chk("rst7_ctrl", {in_ready, out_valid, busy, round_idx}, {1'b1, 1'b0, 1'b0, 4'd0});
        chk("rst7_state_reg", dut.state_reg_q, 128'h0);
        send(C3_PT, C3_KEY);
        wait_ov("rst7_out_valid");
        chk("rst7_ct", ciphertext, C3_CT);
        @(negedge clk);

        // Back-to-back with in_valid held and out_ready tied high
        in_valid  = 1'b1;
        plaintext = C3_PT;
        key       = C3_KEY;
        chk("b2b_ready", {255'h0, in_ready}, 256'h1);
        @(negedge clk);
        plaintext = F_PT;
        key       = F_KEY;
        wait_ov("b2b_ov1");
        t1 = cyc;
        chk("b2b_ct1", ciphertext, C3_CT);
        @(negedge clk);
        chk("b2b_idle", {in_ready, out_valid, busy}, {1'b1, 1'b0, 1'b0});
        chk("b2b_zeroize", dut.state_reg_q, 128'h0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_accept2", {busy, round_idx}, {1'b1, 4'd1});
        wait_ov("b2b_ov2");
        chk("b2b_spacing", cyc - t1, 16);
        chk("b2b_ct2", ciphertext, F_CT);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
